ssp_slave_framer: RTL

SSP_SLAVE_FRAMER -- requirements
Module: ssp_slave_framer

---
 rtl/ssp_slave_framer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ssp_slave_framer.sv
// rtl/ssp_slave_framer.sv - SSP mode-0 slave that frames 16-bit UART register accesses
module ssp_slave_framer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        SSP_SSEL,
    input  logic        SSP_SCK,
    input  logic        SSP_MOSI,
    output logic        SSP_MISO,
    input  logic [11:0] SSP_DO,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic [11:0] SSP_DI,
    output logic        SSP_En,
    output logic        SSP_EOC,
    output logic        Frm_Err,
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ssel_sync, sck_sync, mosi_sync;
    logic                   ssel_d, sck_d;
    // Marks when the synchronizer and history flops hold real pin samples,
    // so a select that was already high across reset is not seen as an edge.
    logic [SYNC_STAGES:0]   fill_sr;

    logic        ssel_s, sck_s, mosi_s, sync_valid;
    logic        ssel_rise, ssel_fall, sck_rise, sck_fall;

    logic [4:0]  bit_cnt;
    logic        overrun;
    logic [10:0] rx_sr;
    logic [10:0] tx_sr;

    logic        start, deselect, shift_in, ld_hdr, ld_di, set_ovr;
    logic        eoc_nxt, err_nxt;

    assign ssel_s     = ssel_sync[SYNC_STAGES-1];
    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sync_valid = fill_sr[SYNC_STAGES];

    assign ssel_rise  = sync_valid & ssel_s & ~ssel_d;
    assign ssel_fall  = sync_valid & ~ssel_s & ssel_d;
    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;

    assign Busy       = (state != IDLE);

    // Input synchronizers plus one history flop each for edge detection
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ssel_sync <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            ssel_d    <= 1'b0;
            sck_d     <= 1'b0;
            fill_sr   <= '0;
        end else begin
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSP_SSEL};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SSP_SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SSP_MOSI};
            ssel_d    <= ssel_s;
            sck_d     <= sck_s;
            fill_sr   <= {fill_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Next-state and per-cycle control decode; deselect outranks a same-cycle SCK edge
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        deselect  = 1'b0;
        shift_in  = 1'b0;
        ld_hdr    = 1'b0;
        ld_di     = 1'b0;
        set_ovr   = 1'b0;
        eoc_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ssel_rise) begin
                    state_nxt = HDR;
                    start     = 1'b1;
                end
            end
            HDR: begin
                if (ssel_fall) begin
                    state_nxt = IDLE;
                    deselect  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (sck_rise) begin
                    shift_in = 1'b1;
                    if (bit_cnt == 5'd3) begin
                        ld_hdr    = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (ssel_fall) begin
                    state_nxt = IDLE;
                    deselect  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (sck_rise) begin
                    shift_in = 1'b1;
                    if (bit_cnt == 5'd15) begin
                        ld_di     = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (ssel_fall) begin
                    state_nxt = IDLE;
                    deselect  = 1'b1;
                    eoc_nxt   = ~overrun;
                    err_nxt   = overrun;
                end else if (sck_rise) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, receive/transmit shifters, register-file outputs and strobes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            overrun  <= 1'b0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            SSP_MISO <= 1'b0;
            SSP_RA   <= '0;
            SSP_WnR  <= 1'b0;
            SSP_DI   <= '0;
            SSP_En   <= 1'b0;
            SSP_EOC  <= 1'b0;
            Frm_Err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            SSP_En  <= ld_di;
            SSP_EOC <= eoc_nxt;
            Frm_Err <= err_nxt;

            if (start) begin
                bit_cnt <= '0;
                overrun <= 1'b0;
                rx_sr   <= '0;
            end
            if (shift_in) begin
                rx_sr   <= {rx_sr[9:0], mosi_s};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (ld_hdr) begin
                SSP_RA  <= rx_sr[2:0];
                SSP_WnR <= mosi_s;
            end
            if (ld_di) begin
                SSP_DI <= {rx_sr[10:0], mosi_s};
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end

            // MISO only moves on SCK falls; fall 4 loads read data, falls 5-15 shift it out
            if (deselect) begin
                SSP_MISO <= 1'b0;
            end else if (sck_fall) begin
                if (state == DATA && bit_cnt == 5'd4) begin
                    SSP_MISO <= SSP_DO[11];
                    tx_sr    <= SSP_DO[10:0];
                end else if (state == DATA) begin
                    SSP_MISO <= tx_sr[10];
                    tx_sr    <= {tx_sr[9:0], 1'b0};
                end else begin
                    SSP_MISO <= 1'b0;
                end
            end
        end
    end

endmodule
